// File: rtl/otter_pkg.sv
// rtl/otter_pkg.sv - shared widths, types and index helper for the otter register file
package otter_pkg;

    localparam int XLEN       = 32;
    localparam int NREGS      = 32;
    localparam int REG_ADDR_W = $clog2(NREGS);

    typedef logic [XLEN-1:0]       word_t;
    typedef logic [REG_ADDR_W-1:0] reg_idx_t;

    // True for indices that name a real, writable register (not x0, not past NREGS).
    function automatic logic idx_writable(input reg_idx_t idx);
        return (idx != '0) && (int'(idx) < NREGS);
    endfunction

endpackage

// File: rtl/otter_scoreboard.sv
// rtl/otter_scoreboard.sv - pending-write busy bits with issue-over-writeback priority
// Busy lookups are raw registered state; any same-cycle masking is done by the caller.
module otter_scoreboard
    import otter_pkg::*;
(
    input  logic     i_clk,
    input  logic     i_rst_n,
    input  logic     i_issue_en,
    input  reg_idx_t i_issue_rd,
    input  logic     i_wb_en,
    input  reg_idx_t i_wb_addr,
    input  reg_idx_t i_rs1_addr,
    input  reg_idx_t i_rs2_addr,
    output logic     o_rs1_busy,
    output logic     o_rs2_busy
);

    logic [NREGS-1:0] r_busy;
    logic [NREGS-1:0] w_set;
    logic [NREGS-1:0] w_clr;

    // Bit 0 is never set, so x0 reads as not busy without a special case.
    always_comb begin
        w_set = '0;
        w_clr = '0;
        for (int i = 1; i < NREGS; i++) begin
            w_set[i] = i_issue_en && (int'(i_issue_rd) == i);
            w_clr[i] = i_wb_en && (int'(i_wb_addr) == i);
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_busy <= '0;
        end else begin
            r_busy <= (r_busy & ~w_clr) | w_set;
        end
    end

    assign o_rs1_busy = idx_writable(i_rs1_addr) ? r_busy[i_rs1_addr] : 1'b0;
    assign o_rs2_busy = idx_writable(i_rs2_addr) ? r_busy[i_rs2_addr] : 1'b0;

endmodule

// File: rtl/otter_reg_file.sv
// rtl/otter_reg_file.sv - 32 x XLEN register file, two async reads, one sync write, busy scoreboard
// Optional same-cycle write-back forwarding: define REG_FILE_BYPASS_EN.
module otter_reg_file
    import otter_pkg::*;
(
    input  logic     CLK,
    input  logic     RST_N,
    input  reg_idx_t rs1_addr,
    input  reg_idx_t rs2_addr,
    output word_t    rs1_data,
    output word_t    rs2_data,
    input  logic     wb_en,
    input  reg_idx_t wb_addr,
    input  word_t    wb_data,
    input  logic     issue_en,
    input  reg_idx_t issue_rd,
    output logic     rs1_busy,
    output logic     rs2_busy,
    output logic     stall
);

    word_t r_regs [NREGS];
    word_t w_rs1_reg;
    word_t w_rs2_reg;
    logic  w_sb_rs1_busy;
    logic  w_sb_rs2_busy;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            for (int i = 0; i < NREGS; i++) begin
                r_regs[i] <= '0;
            end
        end else if (wb_en && idx_writable(wb_addr)) begin
            r_regs[wb_addr] <= wb_data;
        end
    end

    assign w_rs1_reg = idx_writable(rs1_addr) ? r_regs[rs1_addr] : '0;
    assign w_rs2_reg = idx_writable(rs2_addr) ? r_regs[rs2_addr] : '0;

    otter_scoreboard u_scoreboard (
        .i_clk      (CLK),
        .i_rst_n    (RST_N),
        .i_issue_en (issue_en),
        .i_issue_rd (issue_rd),
        .i_wb_en    (wb_en),
        .i_wb_addr  (wb_addr),
        .i_rs1_addr (rs1_addr),
        .i_rs2_addr (rs2_addr),
        .o_rs1_busy (w_sb_rs1_busy),
        .o_rs2_busy (w_sb_rs2_busy)
    );

`ifdef REG_FILE_BYPASS_EN
    logic w_fwd1;
    logic w_fwd2;
    logic w_iss1;
    logic w_iss2;

    assign w_fwd1 = wb_en && idx_writable(wb_addr) && (wb_addr == rs1_addr);
    assign w_fwd2 = wb_en && idx_writable(wb_addr) && (wb_addr == rs2_addr);
    assign w_iss1 = issue_en && (issue_rd == rs1_addr);
    assign w_iss2 = issue_en && (issue_rd == rs2_addr);

    assign rs1_data = w_fwd1 ? wb_data : w_rs1_reg;
    assign rs2_data = w_fwd2 ? wb_data : w_rs2_reg;
    // A write-back landing now already resolves the hazard unless a new producer claims the same rd.
    assign rs1_busy = w_sb_rs1_busy && !(w_fwd1 && !w_iss1);
    assign rs2_busy = w_sb_rs2_busy && !(w_fwd2 && !w_iss2);
`else
    assign rs1_data = w_rs1_reg;
    assign rs2_data = w_rs2_reg;
    assign rs1_busy = w_sb_rs1_busy;
    assign rs2_busy = w_sb_rs2_busy;
`endif

    assign stall = rs1_busy | rs2_busy;

endmodule

// File: tb/tb_otter_reg_file.sv
// tb/tb_otter_reg_file.sv - directed and random checks of otter_reg_file against an array model
module tb_otter_reg_file;
    import otter_pkg::*;

`ifdef REG_FILE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic     CLK;
    logic     RST_N;
    reg_idx_t rs1_addr, rs2_addr, wb_addr, issue_rd;
    word_t    rs1_data, rs2_data, wb_data;
    logic     wb_en, issue_en;
    logic     rs1_busy, rs2_busy, stall;

    int vectors     = 0;
    int miscompares = 0;

    word_t m_regs [NREGS];
    bit    m_busy [NREGS];

    otter_reg_file dut (
        .CLK      (CLK),
        .RST_N    (RST_N),
        .rs1_addr (rs1_addr),
        .rs2_addr (rs2_addr),
        .rs1_data (rs1_data),
        .rs2_data (rs2_data),
        .wb_en    (wb_en),
        .wb_addr  (wb_addr),
        .wb_data  (wb_data),
        .issue_en (issue_en),
        .issue_rd (issue_rd),
        .rs1_busy (rs1_busy),
        .rs2_busy (rs2_busy),
        .stall    (stall)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [XLEN-1:0] obs, input logic [XLEN-1:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic word_t exp_data(input reg_idx_t a);
        if (a == 0 || int'(a) >= NREGS) return '0;
        if (BYP && wb_en && wb_addr == a) return wb_data;
        return m_regs[a];
    endfunction

    function automatic logic exp_busy(input reg_idx_t a);
        if (a == 0 || int'(a) >= NREGS) return 1'b0;
        if (BYP && wb_en && wb_addr == a && !(issue_en && issue_rd == a)) return 1'b0;
        return m_busy[a];
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NREGS; i++) begin
            m_regs[i] = '0;
            m_busy[i] = 1'b0;
        end
    endtask

    // Applied right after the edge, while the inputs still hold the values that were sampled.
    task automatic model_edge();
        if (wb_en && wb_addr != 0) begin
            m_regs[wb_addr] = wb_data;
            m_busy[wb_addr] = 1'b0;
        end
        if (issue_en && issue_rd != 0) m_busy[issue_rd] = 1'b1;
    endtask

    task automatic check_outputs(input string tag);
        logic eb1, eb2;
        eb1 = exp_busy(rs1_addr);
        eb2 = exp_busy(rs2_addr);
        check({tag, ".rs1_data"}, rs1_data, exp_data(rs1_addr));
        check({tag, ".rs2_data"}, rs2_data, exp_data(rs2_addr));
        check({tag, ".rs1_busy"}, XLEN'(rs1_busy), XLEN'(eb1));
        check({tag, ".rs2_busy"}, XLEN'(rs2_busy), XLEN'(eb2));
        check({tag, ".stall"},    XLEN'(stall),    XLEN'(eb1 | eb2));
    endtask

    task automatic drive(input int r1, input int r2, input bit we, input int wa, input word_t wd,
                         input bit ie, input int ir);
        rs1_addr = reg_idx_t'(r1);
        rs2_addr = reg_idx_t'(r2);
        wb_en    = we;
        wb_addr  = reg_idx_t'(wa);
        wb_data  = wd;
        issue_en = ie;
        issue_rd = reg_idx_t'(ir);
        #1;
    endtask

    task automatic tick(input string tag);
        check_outputs(tag);
        @(posedge CLK);
        model_edge();
        #1;
    endtask

    function automatic int rnd_idx();
        return ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, NREGS - 1)) : int'($urandom_range(0, 7));
    endfunction

    initial begin
        model_reset();
        RST_N = 1'b0;
        drive(0, 0, 0, 0, '0, 0, 0);
        check_outputs("reset_hold");
        repeat (2) @(posedge CLK);
        #1 RST_N = 1'b1;

        // Reset mid-cycle wipes data and pending busy bits immediately.
        drive(5, 6, 1, 5, 32'h1234, 1, 6);
        tick("t1_preload");
        drive(5, 6, 0, 0, '0, 0, 0);
        check("t1_x5_loaded", rs1_data, 32'h1234);
        check("t1_x6_busy", XLEN'(rs2_busy), 1);
        #2 RST_N = 1'b0;
        #1 model_reset();
        check_outputs("t1_async");
        check("t1_x5_zero", rs1_data, 0);
        check("t1_stall_zero", XLEN'(stall), 0);
        @(posedge CLK);
        #2 RST_N = 1'b1;

        // Write then read; x0 ignores writes.
        drive(0, 0, 1, 7, 32'hDEADBEEF, 0, 0);
        tick("t2_wr7");
        drive(7, 0, 1, 0, 32'hFFFFFFFF, 0, 0);
        check("t2_x7", rs1_data, 32'hDEADBEEF);
        tick("t2_wr0");
        drive(0, 0, 0, 0, '0, 0, 0);
        check("t2_x0", rs1_data, 0);
        tick("t2_rd0");

        // Read during write.
        drive(0, 9, 1, 9, 32'hA5A5A5A5, 0, 0);
        check("t3_rdw", rs2_data, BYP ? 32'hA5A5A5A5 : 32'h0);
        tick("t3_rdw");
        drive(0, 9, 0, 0, '0, 0, 0);
        check("t3_after", rs2_data, 32'hA5A5A5A5);
        tick("t3_after");

        // Scoreboard set, stall, clear on write-back.
        drive(0, 0, 0, 0, '0, 1, 3);
        tick("t4_issue");
        drive(3, 0, 0, 0, '0, 0, 0);
        check("t4_busy", XLEN'(rs1_busy), 1);
        check("t4_stall", XLEN'(stall), 1);
        tick("t4_busy");
        drive(3, 0, 1, 3, 32'h42, 0, 0);
        check("t4_wb_busy", XLEN'(rs1_busy), BYP ? 0 : 1);
        tick("t4_wb");
        drive(3, 0, 0, 0, '0, 0, 0);
        check("t4_cleared", XLEN'(rs1_busy), 0);
        check("t4_data", rs1_data, 32'h42);
        tick("t4_cleared");

        // Same-edge issue and write-back: data written, new producer pending.
        drive(4, 0, 1, 4, 32'h10, 1, 4);
        tick("t5_both");
        drive(4, 0, 0, 0, '0, 0, 0);
        check("t5_busy4", XLEN'(rs1_busy), 1);
        check("t5_data4", rs1_data, 32'h10);
        tick("t5_after");

        // Issue to x0 never sets busy.
        drive(0, 0, 0, 0, '0, 1, 0);
        check("t6_stall_now", XLEN'(stall), 0);
        tick("t6_issue0");
        drive(0, 0, 0, 0, '0, 0, 0);
        check("t6_stall", XLEN'(stall), 0);
        check("t6_data", rs1_data, 0);
        tick("t6_after");

        for (int n = 0; n < 400; n++) begin
            drive(rnd_idx(), rnd_idx(), 1'($urandom_range(0, 1)), rnd_idx(), word_t'($urandom()),
                  ($urandom_range(0, 2) == 0), rnd_idx());
            tick("rand");
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
